// File: rtl/pla_harness_pkg.sv
// -----------------------------------------------------------------------------
// pla_harness_pkg
//   Shared definitions for the PLA benchmark stimulus/response harness blocks
//   and the benchmark wrappers.
//   - PLA_NUM_IN     : input-vector width of the flattened benchmark netlists
//   - DEF_SIG_POLY   : default MISR feedback polynomial (bit i set = tap i)
//   - DEF_SIG_SEED   : default MISR value loaded on start
//   - harness_state_t: run-control FSM states
// -----------------------------------------------------------------------------
package pla_harness_pkg;

    localparam int          PLA_NUM_IN   = 25;
    localparam logic [31:0] DEF_SIG_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] DEF_SIG_SEED = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } harness_state_t;

endpackage : pla_harness_pkg

// File: rtl/pla_misr.sv
// -----------------------------------------------------------------------------
// pla_misr
//   Single-input multiple-input-signature register. Each enabled cycle shifts
//   the signature left one place, folds the polynomial back in when the MSB
//   falls off, and XORs the serial response bit into bit 0. Load has priority
//   over shift so a new run always starts from a clean seed.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (sig <= RST_VAL)
//   load     in   load seed into the signature
//   seed     in   SIG_W  value loaded when load=1
//   shift_en in   advance the signature by one response bit
//   din      in   serial response bit
//   sig      out  SIG_W  current signature
// -----------------------------------------------------------------------------
module pla_misr #(
    parameter int                 SIG_W    = 32,
    parameter logic [SIG_W-1:0]   SIG_POLY = 32'h04C1_1DB7,
    parameter logic [SIG_W-1:0]   RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             shift_en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_next;

    // NOTE: every variable assigned in always_comb gets an unconditional
    // default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1]) begin
            sig_next = sig_next ^ SIG_POLY;
        end
        sig_next[0] = sig_next[0] ^ din;
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // flop samples the pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= RST_VAL;
        end else if (load) begin
            sig <= seed;
        end else if (shift_en) begin
            sig <= sig_next;
        end
    end

endmodule : pla_misr

// File: rtl/pla_stim_capture.sv
// -----------------------------------------------------------------------------
// pla_stim_capture
//   Drives a run of consecutive input vectors into one combinational PLA
//   benchmark instance and compacts its y0 responses into a MISR signature
//   and a ones-count. Each vector is held for SETTLE cycles (HOLD) and then
//   sampled in one SAMPLE cycle, so each vector costs SETTLE+1 cycles.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle run request, honoured only in IDLE
//   abort       in   terminate the run in progress
//   start_vec   in   NUM_IN    first vector of the run
//   num_vecs    in   NUM_IN+1  number of vectors, 0..2^NUM_IN
//   x_out       out  NUM_IN    registered vector to the benchmark inputs
//   y_in        in   benchmark output y0
//   busy        out  high from the accepted start until done or abort
//   done        out  one-cycle pulse at normal completion
//   signature   out  SIG_W     MISR result, held until the next start
//   ones_count  out  NUM_IN+1  sampled y_in=1 count, held until the next start
// -----------------------------------------------------------------------------
module pla_stim_capture
    import pla_harness_pkg::*;
#(
    parameter int               NUM_IN   = PLA_NUM_IN,
    parameter int               SETTLE   = 1,
    parameter int               SIG_W    = 32,
    parameter logic [SIG_W-1:0] SIG_POLY = DEF_SIG_POLY,
    parameter logic [SIG_W-1:0] SIG_SEED = DEF_SIG_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_IN-1:0] start_vec,
    input  logic [NUM_IN:0]   num_vecs,
    output logic [NUM_IN-1:0] x_out,
    input  logic              y_in,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [NUM_IN:0]   ones_count
);

    // Settle timer sized for SETTLE-1; kept at one bit when SETTLE<=1 so the
    // HOLD logic stays legal even when HOLD is never entered.
    localparam int                 CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    // State entered whenever a new vector is presented on x_out.
    localparam harness_state_t     VEC_ST   = (SETTLE > 0) ? ST_HOLD : ST_SAMPLE;

    harness_state_t     state;
    logic [NUM_IN:0]    remaining;
    logic [CNT_W-1:0]   settle_cnt;
    logic               accept;
    logic               sampling;
    logic               last_vec;

    assign accept   = (state == ST_IDLE) && start;
    assign sampling = (state == ST_SAMPLE);
    assign last_vec = (remaining == (NUM_IN+1)'(1));

    // The MISR shifts on every SAMPLE cycle, including one cut short by
    // abort, so the partial signature covers exactly the counted samples.
    pla_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .RST_VAL  (SIG_SEED)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .seed     (SIG_SEED),
        .shift_en (sampling),
        .din      (y_in),
        .sig      (signature)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            x_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            settle_cnt <= '0;
            ones_count <= '0;
        end else begin
            // done is a pulse: raised only on the edge that enters FIN.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // abort is ignored here, so start wins a tie with it.
                    if (start) begin
                        x_out      <= start_vec;
                        remaining  <= num_vecs;
                        ones_count <= '0;
                        settle_cnt <= '0;
                        if (num_vecs == '0) begin
                            // Empty run: complete immediately.
                            state <= ST_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= VEC_ST;
                            busy  <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    ones_count <= ones_count + (NUM_IN+1)'(y_in);
                    remaining  <= remaining - (NUM_IN+1)'(1);
                    if (abort) begin
                        // abort beats completion; x_out stays on the
                        // vector that was just sampled.
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (last_vec) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        // Natural NUM_IN-bit wrap: all-ones steps to zero.
                        x_out <= x_out + NUM_IN'(1);
                        state <= VEC_ST;
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : pla_stim_capture

// File: tb/tb_pla_stim_capture.sv
// -----------------------------------------------------------------------------
// tb_pla_stim_capture
//   Scoreboarded bench for pla_stim_capture. Runs expected to complete push
//   their expected {signature, ones_count, final x_out} into a queue; the
//   monitor pops and compares on every done pulse. A second instance with
//   SETTLE=0 covers the zero-settle variant.
// -----------------------------------------------------------------------------
module tb_pla_stim_capture;

    localparam int          NI   = 25;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]   sig;
        logic [NI:0]   ones;
        logic [NI-1:0] x;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NI-1:0] start_vec = '0;
    logic [NI:0]   num_vecs = '0;
    logic [NI-1:0] x_out;
    logic          y_in;
    logic          busy;
    logic          done;
    logic [31:0]   signature;
    logic [NI:0]   ones_count;

    logic          start0 = 1'b0;
    logic          abort0 = 1'b0;
    logic [NI-1:0] start_vec0 = '0;
    logic [NI:0]   num_vecs0 = '0;
    logic [NI-1:0] x_out0;
    logic          y_in0;
    logic          busy0;
    logic          done0;
    logic [31:0]   signature0;
    logic [NI:0]   ones_count0;

    int            mode = 0;
    logic [NI-1:0] mask = '0;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pla_stim_capture #(.NUM_IN(NI), .SETTLE(1), .SIG_W(32), .SIG_POLY(POLY), .SIG_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .start_vec(start_vec), .num_vecs(num_vecs), .x_out(x_out), .y_in(y_in),
        .busy(busy), .done(done), .signature(signature), .ones_count(ones_count)
    );

    pla_stim_capture #(.NUM_IN(NI), .SETTLE(0), .SIG_W(32), .SIG_POLY(POLY), .SIG_SEED(SEED)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .start_vec(start_vec0), .num_vecs(num_vecs0), .x_out(x_out0), .y_in(y_in0),
        .busy(busy0), .done(done0), .signature(signature0), .ones_count(ones_count0)
    );

    // Stand-in benchmark: y0 as a function of the presented vector.
    function automatic logic yf(input logic [NI-1:0] x, input int md, input logic [NI-1:0] mk);
        case (md)
            0:       return x[0];
            1:       return x[NI-1];
            2:       return 1'b1;
            default: return ^(x & mk);
        endcase
    endfunction

    always_comb y_in  = yf(x_out, mode, mask);
    always_comb y_in0 = yf(x_out0, mode, mask);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model of a complete run.
    task automatic model(input logic [NI-1:0] sv, input int n, input int md,
                         input logic [NI-1:0] mk, output exp_t e);
        logic [NI-1:0] x = sv;
        logic [31:0]   s = SEED;
        logic [NI:0]   o = '0;
        logic          y;
        for (int i = 0; i < n; i++) begin
            y = yf(x, md, mk);
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {31'h0, y};
            o = o + (NI+1)'(y);
            if (i != n - 1) x = x + NI'(1);
        end
        e.sig  = s;
        e.ones = o;
        e.x    = x;
    endtask

    task automatic push_const(input logic [31:0] s, input logic [NI:0] o, input logic [NI-1:0] x);
        exp_t e;
        e.sig  = s;
        e.ones = o;
        e.x    = x;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input logic [NI-1:0] sv, input logic [NI:0] n);
        start_vec = sv;
        num_vecs  = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts negedges until done is seen, and negedges with busy high.
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 5000) begin
            tests++;
            fails++;
            $display("FAIL wait_done: no done within 5000 cycles");
        end
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_done: got done with empty queue, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_signature", 64'(signature), 64'(e.sig));
                    check("sb_ones_count", 64'(ones_count), 64'(e.ones));
                    check("sb_x_out", 64'(x_out), 64'(e.x));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, bc, seen;
        exp_t e;
        logic [NI-1:0] sv;
        int n;

        // Reset state.
        @(negedge clk);
        check("rst_x_out", 64'(x_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_signature", 64'(signature), 64'(SEED));
        check("rst_ones_count", 64'(ones_count), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run: y = x[0], vectors 0..3 -> 0,1,0,1.
        mode = 0;
        push_const(32'h0000_0005, 26'd2, 25'd3);
        do_start(25'd0, 26'd4);
        wait_done(cyc, bc);
        check("basic_done_cycle", 64'(cyc), 64'd8);
        check("basic_busy_cycles", 64'(bc), 64'd8);
        @(negedge clk);
        check("basic_done_width", 64'(done), 64'h0);
        repeat (3) @(negedge clk);
        check("basic_x_hold", 64'(x_out), 64'd3);

        // Wrap: 0x1FFFFFF -> 0, y = x[24].
        mode = 1;
        push_const(32'h0000_0002, 26'd1, 25'd0);
        do_start(25'h1FF_FFFF, 26'd2);
        wait_done(cyc, bc);
        check("wrap_done_cycle", 64'(cyc), 64'd4);
        @(negedge clk);

        // Zero-length run.
        push_const(SEED, 26'd0, 25'h0AB_CDE);
        do_start(25'h0AB_CDE, 26'd0);
        wait_done(cyc, bc);
        check("zero_done_cycle", 64'(cyc), 64'd0);
        @(negedge clk);
        check("zero_done_width", 64'(done), 64'h0);

        // Abort during the third SAMPLE, y = 1.
        mode = 2;
        do_start(25'd0, 26'd100);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_ones_count", 64'(ones_count), 64'd3);
        check("abort_signature", 64'(signature), 64'h7);
        check("abort_x_out", 64'(x_out), 64'd2);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_x_frozen", 64'(x_out), 64'd2);

        // Start while busy is ignored.
        mode = 0;
        push_const(32'h0000_0005, 26'd2, 25'd3);
        do_start(25'd0, 26'd4);
        @(negedge clk);
        do_start(25'h100, 26'd7);
        wait_done(cyc, bc);
        check("busy_start_done_cycle", 64'(cyc), 64'd6);
        @(negedge clk);

        // Asynchronous reset mid-run (y = 1 so state is non-trivial).
        mode = 2;
        do_start(25'd0, 26'd4);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_x_out", 64'(x_out), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_signature", 64'(signature), 64'(SEED));
        check("midrst_ones_count", 64'(ones_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 0;
        push_const(32'h0000_0005, 26'd2, 25'd3);
        do_start(25'd0, 26'd4);
        wait_done(cyc, bc);
        check("postrst_done_cycle", 64'(cyc), 64'd8);
        check("postrst_busy_cycles", 64'(bc), 64'd8);
        @(negedge clk);

        // SETTLE=0 instance: same vectors in 4 cycles.
        start_vec0 = '0;
        num_vecs0  = 26'd4;
        start0     = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("s0_done_cycle", 64'(cyc), 64'd4);
        check("s0_signature", 64'(signature0), 64'h5);
        check("s0_ones_count", 64'(ones_count0), 64'd2);
        check("s0_x_out", 64'(x_out0), 64'd3);
        @(negedge clk);

        // Sweep against the reference model.
        mode = 3;
        for (int k = 0; k < 6; k++) begin
            sv   = (k == 0) ? 25'h1FF_FF00 : NI'($urandom);
            n    = $urandom_range(1, 512);
            mask = NI'($urandom);
            model(sv, n, mode, mask, e);
            exp_q.push_back(e);
            do_start(sv, (NI+1)'(n));
            wait_done(cyc, bc);
            check("sweep_done_cycle", 64'(cyc), 64'(2 * n));
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pla_stim_capture
